ps2_mouse_cursor: RTL and testbench
===================================

Name: ps2_mouse_cursor

Overview:
- Downstream consumer of the PS/2 mouse receive path (ps2rx byte stream after the init sequence reaches streaming mode).
- Frames the standard 3-byte movement packet and re-synchronises on framing errors.
- Decodes buttons and 9-bit signed deltas, then accumulates a clamped screen-space cursor position for the VGA drawing logic.

Parameters:
- H_RES, 640, horizontal screen size; cursor_x range is 0..H_RES-1
- V_RES, 480, vertical screen size; cursor_y range is 0..V_RES-1
- INIT_X, 320, cursor_x reset value
- INIT_Y, 240, cursor_y reset value
- TIMEOUT_CYCLES, 250000, idle cycles mid-packet before resync (only used with the optional feature)

Ports:
- clk  in  1  system clock (same domain as ps2rx)
- rst  in  1  asynchronous, active-low reset
- stream_en  in  1  high once mouse init has completed; low holds the framer idle
- byte_valid  in  1  one-cycle strobe; connects to ps2rx rx_done_tick
- byte_data  in  8  received byte; connects to ps2rx dout
- pkt_valid  out  1  one-cycle pulse when a packet has been applied
- buttons  out  3  {middle, right, left} from the last good packet
- dx  out  9  signed X delta of the last packet, after overflow rule
- dy  out  9  signed Y delta of the last packet, PS/2 sense (up positive), after overflow rule
- cursor_x  out  10  current cursor column
- cursor_y  out  10  current cursor row
- sync_err  out  1  one-cycle pulse when a byte or packet is discarded

Behaviour:
- Reset (rst low, asynchronous):
  - state=WAIT_B0; pkt_valid=0, sync_err=0; buttons=0, dx=0, dy=0
  - cursor_x=INIT_X, cursor_y=INIT_Y; internal byte0/byte1 registers cleared
  - Reset mid-packet discards the partial packet.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, APPLY.
- WAIT_B0:
  - byte_valid with byte_data[3]=1: latch byte0, go to WAIT_B1.
  - byte_valid with byte_data[3]=0: pulse sync_err next cycle, stay in WAIT_B0.
- WAIT_B1: byte_valid: latch byte1 (X movement), go to WAIT_B2.
- WAIT_B2: byte_valid: latch byte2 (Y movement), go to APPLY.
- APPLY (exactly one cycle):
  - Register outputs; pkt_valid=1 during the cycle after APPLY.
  - Return to WAIT_B0.
- Latency: pkt_valid and the updated cursor_x/cursor_y/buttons/dx/dy appear 2 cycles after the byte_valid of byte 2. All update in the same cycle.
- Delta decode:
  - dx = {byte0[4], byte1}, dy = {byte0[5], byte2} (9-bit two's complement).
  - If byte0[6] (x_overflow) is set, dx=0. If byte0[7] (y_overflow) is set, dy=0. Buttons still update.
- Cursor arithmetic (12-bit signed intermediates, no wrap):
  - cursor_x' = clamp(cursor_x + dx, 0, H_RES-1)
  - cursor_y' = clamp(cursor_y - dy, 0, V_RES-1) (screen Y grows downward)
- byte_valid arriving while in APPLY is ignored. A PS/2 byte takes roughly 1 ms, so this cannot occur in practice; the bench still checks it.
- stream_en low:
  - FSM forced to WAIT_B0 on the next edge; any partial packet is dropped without sync_err.
  - Bytes are ignored; cursor and buttons hold their values.
- Simultaneous events: stream_en falling during APPLY still completes APPLY (the packet is applied).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MOUSE_PKT_TIMEOUT_EN.
- Defined:
  - Idle counter clears on every byte_valid and counts while in WAIT_B1 or WAIT_B2.
  - On reaching TIMEOUT_CYCLES: go to WAIT_B0 and pulse sync_err once.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter. A lost byte is only recovered through the bit-3 check or a stream_en toggle.

Decomposition:
- Shared package mouse_pkg:
  - mouse_packet_t (packed struct: overflow, sign, always_1 and button bits, x/y movement bytes), reused by top.
  - Enum mouse_frame_state_t.
  - Constant ALWAYS1_BIT=3.
- One natural sub-module, mouse_axis_accum: signed add plus clamp for one axis, parameterised by limit, with one instance per axis.

Test Plan:
- Reset, then stream_en=1 and bytes 08,05,03 -> pkt_valid 2 cycles after the 3rd byte; dx=+5, dy=+3; cursor=(325,237); buttons=0.
- From reset, bytes 19,FB,00 (left button, X sign set) -> dx=-5; cursor=(315,240); buttons=001.
- Cursor at (2,478), then bytes 38,F0,F0 -> dx=-16, dy=-16; cursor clamped to (0,479).
- Misaligned stream 05,08,01,02 -> sync_err on 05; packet {08,01,02} applied with dx=+1, dy=+2.
- Bytes 48,7F,01 (x_overflow) -> dx=0, dy=+1; cursor_x unchanged, cursor_y decremented by 1.
- With MOUSE_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte 08, 100 idle cycles -> sync_err; next 08,01,01 applies normally. Separately, rst low mid-packet -> cursor=(320,240), no pkt_valid.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared types for the PS/2 mouse packet framer and cursor accumulator.
package mouse_pkg;

  // Byte 0 of every movement packet has this bit hard-wired to 1.
  localparam int ALWAYS1_BIT = 3;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    APPLY
  } mouse_frame_state_t;

  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic       always_1;
    logic       middle;
    logic       right;
    logic       left;
    logic [7:0] x_move;
    logic [7:0] y_move;
  } mouse_packet_t;

endpackage

// File: rtl/ps2_mouse_cursor_if.sv
// Byte-stream input and decoded cursor output bundle for ps2_mouse_cursor.
interface ps2_mouse_cursor_if;
  import mouse_pkg::*;

  // byte_valid qualifies byte_data for exactly one cycle; there is no ready,
  // so the consumer either takes the byte on that edge or drops it.
  logic               stream_en;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               pkt_valid;
  logic [2:0]         buttons;
  logic [8:0]         dx;
  logic [8:0]         dy;
  logic [9:0]         cursor_x;
  logic [9:0]         cursor_y;
  logic               sync_err;
  mouse_frame_state_t frame_state;

  modport master (
    output stream_en, byte_valid, byte_data,
    input  pkt_valid, buttons, dx, dy, cursor_x, cursor_y, sync_err, frame_state
  );

  modport slave (
    input  stream_en, byte_valid, byte_data,
    output pkt_valid, buttons, dx, dy, cursor_x, cursor_y, sync_err, frame_state
  );

endinterface

// File: rtl/mouse_axis_accum.sv
// One cursor axis: signed add (or subtract) of a 9-bit delta, clamped to 0..LIMIT-1.
module mouse_axis_accum #(
  parameter int LIMIT    = 640,
  parameter bit SUBTRACT = 1'b0
) (
  input  logic [9:0] pos,
  input  logic [8:0] delta,
  output logic [9:0] pos_next
);

  localparam logic signed [11:0] MAX_POS = 12'(LIMIT - 1);

  logic signed [11:0] pos_ext;
  logic signed [11:0] delta_ext;
  logic signed [11:0] sum;

  // 12 bits hold 0..1023 +/- 256 without wrapping, so the clamp sees the true sum.
  always_comb begin
    pos_ext   = $signed({2'b00, pos});
    delta_ext = $signed({{3{delta[8]}}, delta});
    sum       = SUBTRACT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
    if (sum < 12'sd0) begin
      pos_next = '0;
    end else if (sum > MAX_POS) begin
      pos_next = MAX_POS[9:0];
    end else begin
      pos_next = sum[9:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// Frames 3-byte PS/2 mouse packets and accumulates a clamped cursor position.
// Optional mid-packet idle timeout: define MOUSE_PKT_TIMEOUT_EN.
module ps2_mouse_cursor
  import mouse_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int INIT_X = 320,
`ifdef MOUSE_PKT_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 250000,
`endif
  parameter int INIT_Y = 240
) (
  input logic               clk,
  input logic               rst,
  ps2_mouse_cursor_if.slave bus
);

  mouse_frame_state_t state, state_next;
  mouse_packet_t      pkt;
  logic               load_b0, load_b1, load_b2;
  logic               sync_err_next;
  logic               apply;
  logic               timeout;

  logic               pkt_valid_q;
  logic               sync_err_q;
  logic [2:0]         buttons_q;
  logic [8:0]         dx_q, dy_q;
  logic [9:0]         cursor_x_q, cursor_y_q;
  logic [8:0]         dx_dec, dy_dec;
  logic [9:0]         cursor_x_next, cursor_y_next;

`ifdef MOUSE_PKT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             mid_packet;

  assign mid_packet = (state == WAIT_B1) || (state == WAIT_B2);
  assign timeout    = mid_packet && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (bus.byte_valid || !mid_packet) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // APPLY always finishes, even if stream_en drops in the same cycle.
  always_comb begin
    state_next    = state;
    load_b0       = 1'b0;
    load_b1       = 1'b0;
    load_b2       = 1'b0;
    sync_err_next = 1'b0;
    case (state)
      WAIT_B0: begin
        if (bus.stream_en && bus.byte_valid) begin
          if (bus.byte_data[ALWAYS1_BIT]) begin
            load_b0    = 1'b1;
            state_next = WAIT_B1;
          end else begin
            sync_err_next = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (!bus.stream_en) begin
          state_next = WAIT_B0;
        end else if (bus.byte_valid) begin
          load_b1    = 1'b1;
          state_next = WAIT_B2;
        end else if (timeout) begin
          sync_err_next = 1'b1;
          state_next    = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (!bus.stream_en) begin
          state_next = WAIT_B0;
        end else if (bus.byte_valid) begin
          load_b2    = 1'b1;
          state_next = APPLY;
        end else if (timeout) begin
          sync_err_next = 1'b1;
          state_next    = WAIT_B0;
        end
      end
      APPLY:   state_next = WAIT_B0;
      default: state_next = WAIT_B0;
    endcase
  end

  assign apply  = (state == APPLY) && pkt.always_1;
  assign dx_dec = pkt.x_ovf ? 9'd0 : {pkt.x_sign, pkt.x_move};
  assign dy_dec = pkt.y_ovf ? 9'd0 : {pkt.y_sign, pkt.y_move};

  mouse_axis_accum #(.LIMIT(H_RES), .SUBTRACT(1'b0)) u_accum_x (
    .pos      (cursor_x_q),
    .delta    (dx_dec),
    .pos_next (cursor_x_next)
  );

  // Screen Y grows downward while PS/2 Y is positive upward.
  mouse_axis_accum #(.LIMIT(V_RES), .SUBTRACT(1'b1)) u_accum_y (
    .pos      (cursor_y_q),
    .delta    (dy_dec),
    .pos_next (cursor_y_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_B0;
      pkt         <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cursor_x_q  <= 10'(INIT_X);
      cursor_y_q  <= 10'(INIT_Y);
    end else begin
      state       <= state_next;
      sync_err_q  <= sync_err_next;
      pkt_valid_q <= apply;
      if (load_b0) begin
        {pkt.y_ovf, pkt.x_ovf, pkt.y_sign, pkt.x_sign,
         pkt.always_1, pkt.middle, pkt.right, pkt.left} <= bus.byte_data;
      end
      if (load_b1) pkt.x_move <= bus.byte_data;
      if (load_b2) pkt.y_move <= bus.byte_data;
      if (apply) begin
        buttons_q  <= {pkt.middle, pkt.right, pkt.left};
        dx_q       <= dx_dec;
        dy_q       <= dy_dec;
        cursor_x_q <= cursor_x_next;
        cursor_y_q <= cursor_y_next;
      end
    end
  end

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.buttons     = buttons_q;
  assign bus.dx          = dx_q;
  assign bus.dy          = dy_q;
  assign bus.cursor_x    = cursor_x_q;
  assign bus.cursor_y    = cursor_y_q;
  assign bus.frame_state = state;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: framing, resync, deltas, clamping, stream_en and reset.
module tb_ps2_mouse_cursor;
  import mouse_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // {buttons[2:0], dx[8:0], dy[8:0], cursor_x[9:0], cursor_y[9:0]}
  logic [40:0] exp_q[$];

  ps2_mouse_cursor_if bus();

  ps2_mouse_cursor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic quiet_window(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | bus.pkt_valid | bus.sync_err;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  // mode 0: plain; 1: stream_en drops during APPLY; 2: extra byte during APPLY
  task automatic apply_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [2:0] ebtn, input logic [8:0] edx, input logic [8:0] edy,
                           input logic [9:0] ex, input logic [9:0] ey, input int mode);
    logic [40:0] e;
    int n;
    exp_q.push_back({ebtn, edx, edy, ex, ey});
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    check_eq("pkt_early", 64'(bus.pkt_valid), 64'd0);
    if (mode == 1) bus.stream_en = 1'b0;
    if (mode == 2) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h08;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n = 1;
    while (!bus.pkt_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    check_eq("pkt_latency", 64'(n), 64'd1);
    e = exp_q.pop_front();
    check_eq("buttons", 64'(bus.buttons), 64'(e[40:38]));
    check_eq("dx", 64'(bus.dx), 64'(e[37:29]));
    check_eq("dy", 64'(bus.dy), 64'(e[28:20]));
    check_eq("cursor_x", 64'(bus.cursor_x), 64'(e[19:10]));
    check_eq("cursor_y", 64'(bus.cursor_y), 64'(e[9:0]));
    @(negedge clk);
    check_eq("pkt_pulse", 64'(bus.pkt_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stream_en  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    do_reset();

    #1;
    check_eq("rst_state", 64'(bus.frame_state), 64'(WAIT_B0));
    check_eq("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    check_eq("rst_sync_err", 64'(bus.sync_err), 64'd0);
    check_eq("rst_buttons", 64'(bus.buttons), 64'd0);
    check_eq("rst_dx", 64'(bus.dx), 64'd0);
    check_eq("rst_dy", 64'(bus.dy), 64'd0);
    check_eq("rst_cursor_x", 64'(bus.cursor_x), 64'd320);
    check_eq("rst_cursor_y", 64'(bus.cursor_y), 64'd240);

    bus.stream_en = 1'b1;
    apply_pkt(8'h08, 8'h05, 8'h03, 3'b000, 9'h005, 9'h003, 10'd325, 10'd237, 0);

    do_reset();
    apply_pkt(8'h19, 8'hFB, 8'h00, 3'b001, 9'h1FB, 9'h000, 10'd315, 10'd240, 0);

    // walk to (2,478), then clamp at left and bottom edges
    apply_pkt(8'h38, 8'h01, 8'h12, 3'b000, 9'h101, 9'h112, 10'd60, 10'd478, 0);
    apply_pkt(8'h18, 8'hC6, 8'h00, 3'b000, 9'h1C6, 9'h000, 10'd2, 10'd478, 0);
    apply_pkt(8'h38, 8'hF0, 8'hF0, 3'b000, 9'h1F0, 9'h1F0, 10'd0, 10'd479, 0);

    // misaligned byte resync
    send_byte(8'h05);
    check_eq("sync_err_misaligned", 64'(bus.sync_err), 64'd1);
    @(negedge clk);
    check_eq("sync_err_pulse", 64'(bus.sync_err), 64'd0);
    apply_pkt(8'h08, 8'h01, 8'h02, 3'b000, 9'h001, 9'h002, 10'd1, 10'd477, 0);

    // x overflow
    apply_pkt(8'h48, 8'h7F, 8'h01, 3'b000, 9'h000, 9'h001, 10'd1, 10'd476, 0);

    // stream_en falls during APPLY; packet still applied
    apply_pkt(8'h0F, 8'h02, 8'hFE, 3'b111, 9'h002, 9'h0FE, 10'd3, 10'd222, 1);
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h01);
    quiet_window("stream_off_ignore", 4);
    check_eq("hold_cursor_x", 64'(bus.cursor_x), 64'd3);
    check_eq("hold_cursor_y", 64'(bus.cursor_y), 64'd222);
    check_eq("hold_buttons", 64'(bus.buttons), 64'd7);

    // partial packet dropped by stream_en toggle, no sync_err
    bus.stream_en = 1'b1;
    send_byte(8'h08);
    send_byte(8'h05);
    bus.stream_en = 1'b0;
    quiet_window("partial_drop_quiet", 3);
    bus.stream_en = 1'b1;
    apply_pkt(8'h08, 8'h03, 8'h01, 3'b000, 9'h003, 9'h001, 10'd6, 10'd221, 0);

    // byte during APPLY is ignored, so the following 01 is a framing error
    apply_pkt(8'h09, 8'h00, 8'h00, 3'b001, 9'h000, 9'h000, 10'd6, 10'd221, 2);
    send_byte(8'h01);
    check_eq("apply_byte_ignored", 64'(bus.sync_err), 64'd1);

    // clamp at right and top edges, then both overflows with right button
    apply_pkt(8'h08, 8'hFF, 8'hFF, 3'b000, 9'h0FF, 9'h0FF, 10'd261, 10'd0, 0);
    apply_pkt(8'h08, 8'hFF, 8'h00, 3'b000, 9'h0FF, 9'h000, 10'd516, 10'd0, 0);
    apply_pkt(8'h08, 8'hFF, 8'h00, 3'b000, 9'h0FF, 9'h000, 10'd639, 10'd0, 0);
    apply_pkt(8'hCA, 8'hFF, 8'hFF, 3'b010, 9'h000, 9'h000, 10'd639, 10'd0, 0);

    // reset mid-packet discards the partial packet
    send_byte(8'h08);
    send_byte(8'h05);
    rst = 1'b0;
    #1;
    check_eq("midrst_cursor_x", 64'(bus.cursor_x), 64'd320);
    check_eq("midrst_cursor_y", 64'(bus.cursor_y), 64'd240);
    check_eq("midrst_buttons", 64'(bus.buttons), 64'd0);
    check_eq("midrst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    quiet_window("midrst_quiet", 4);
    send_byte(8'h01);
    check_eq("midrst_resync", 64'(bus.sync_err), 64'd1);

    repeat (2) @(negedge clk);
    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
